// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with a one-entry skid buffer, so in_ready can come
// straight from a flop. Adds a flush and a saturating count of stalled cycles.
module pipe_stage_buf #(
    parameter int          WIDTH    = 128,
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_pc,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_pc,
    output logic [WIDTH-1:0] out_data,
    output logic             out_bubble,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t             state_p0, stateNext;
    logic [63:0]        mainPc_p0, skidPc_p0;
    logic [WIDTH-1:0]   mainData_p0, skidData_p0;
    logic [CNT_W-1:0]   stallCnt_p0;
    logic               push, pop;
    logic               loadMainIn, loadMainSkid, loadSkid;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready;

    // A flush cancels every storage move, including a TWO->ONE promotion on a same-cycle pop.
    assign loadMainIn   = push && ((state_p0 == EMPTY) || (state_p0 == ONE && pop));
    assign loadSkid     = push && (state_p0 == ONE) && !pop;
    assign loadMainSkid = !flush && (state_p0 == TWO) && pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0    <= EMPTY;
            stallCnt_p0 <= '0;
        end else begin
            state_p0 <= stateNext;
            if (out_valid && !out_ready)
                stallCnt_p0 <= satInc(stallCnt_p0);
        end
    end

    always_comb begin
        stateNext = state_p0;
        if (flush) begin
            stateNext = EMPTY;
        end else begin
            case (state_p0)
                EMPTY:   if (push) stateNext = ONE;
                ONE:     if (push && !pop) stateNext = TWO;
                         else if (!push && pop) stateNext = EMPTY;
                TWO:     if (pop) stateNext = ONE;
                default: stateNext = EMPTY;
            endcase
        end
    end

    // Payload stage: only the main PC is reset so out_pc reads RESET_PC while idle.
    always_ff @(posedge clk) begin
        if (reset)
            mainPc_p0 <= RESET_PC;
        else if (loadMainIn)
            mainPc_p0 <= in_pc;
        else if (loadMainSkid)
            mainPc_p0 <= skidPc_p0;
    end

    always_ff @(posedge clk) begin
        if (loadMainIn)
            mainData_p0 <= in_data;
        else if (loadMainSkid)
            mainData_p0 <= skidData_p0;
        if (loadSkid) begin
            skidPc_p0   <= in_pc;
            skidData_p0 <= in_data;
        end
    end

    always_comb begin
        out_valid  = (state_p0 != EMPTY);
        in_ready   = (state_p0 != TWO);
        out_bubble = (state_p0 == EMPTY);
        occupancy  = state_p0;
        out_pc     = mainPc_p0;
        out_data   = (state_p0 != EMPTY) ? mainData_p0 : '0;
        stall_cnt  = stallCnt_p0;
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed vector table, hand sequences for stall counting,
// then random traffic checked against a queue-based model of the stage.
module tb_pipe_stage_buf;

    localparam int          W     = 32;
    localparam logic [63:0] RPC   = 64'h8000_0000;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [63:0]   in_pc;
    logic [W-1:0]  in_data;
    logic          in_ready, out_valid, out_bubble;
    logic [63:0]   out_pc;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
    logic [31:0]   stall_cnt;
    logic          s_in_ready, s_out_valid, s_out_bubble;
    logic [63:0]   s_out_pc;
    logic [W-1:0]  s_out_data;
    logic [1:0]    s_occupancy;
    logic [3:0]    s_stall_cnt;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(W), .RESET_PC(RPC), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_data(out_data), .out_bubble(out_bubble),
        .occupancy(occupancy), .stall_cnt(stall_cnt));

    pipe_stage_buf #(.WIDTH(W), .RESET_PC(RPC), .CNT_W(4)) dutSat (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_pc(in_pc), .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_pc(s_out_pc), .out_data(s_out_data), .out_bubble(s_out_bubble),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt));

    // Reference model: FIFO of held entries, last main PC, unbounded stall count.
    typedef struct packed { logic [63:0] pc; logic [31:0] data; } ent_t;
    ent_t        mq[$];
    logic [63:0] mLastPc;
    longint      mStall;

    typedef struct {
        logic        rst, fl, iv;
        logic [63:0] pc;
        logic        ordy;
        logic        expVld;
        logic [63:0] expPc;
        logic [1:0]  expOcc;
        logic        expRdy;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [31:0] dataOf(input logic [63:0] pc);
        return pc[31:0] ^ 32'h5A5A_0000;
    endfunction

    function automatic vec_t mk(input logic rst, fl, iv, input logic [63:0] pc, input logic ordy,
                                input logic ev, input logic [63:0] ep, input logic [1:0] eo,
                                input logic er);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.pc = pc; v.ordy = ordy;
        v.expVld = ev; v.expPc = ep; v.expOcc = eo; v.expRdy = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] satTo(input longint v, input longint maxv);
        return (v > maxv) ? 64'(maxv) : 64'(v);
    endfunction

    task automatic checkModel();
        logic [63:0] ePc;
        logic [31:0] eData;
        ePc   = (mq.size() > 0) ? mq[0].pc : mLastPc;
        eData = (mq.size() > 0) ? mq[0].data : 32'h0;
        chk("out_valid",  {63'b0, out_valid},  {63'b0, mq.size() > 0});
        chk("in_ready",   {63'b0, in_ready},   {63'b0, mq.size() < 2});
        chk("out_bubble", {63'b0, out_bubble}, {63'b0, mq.size() == 0});
        chk("occupancy",  {62'b0, occupancy},  64'(mq.size()));
        chk("out_pc",     out_pc,              ePc);
        chk("out_data",   {32'b0, out_data},   {32'b0, eData});
        chk("stall_cnt",  {32'b0, stall_cnt},  satTo(mStall, 64'hFFFF_FFFF));
        chk("sat_stall",  {60'b0, s_stall_cnt}, satTo(mStall, 15));
        chk("sat_pc",     s_out_pc,            ePc);
    endtask

    task automatic step(input logic r, f, iv, input logic [63:0] pc, input logic [31:0] d,
                        input logic ordy);
        logic accept, popped;
        ent_t e;
        reset = r; flush = f; in_valid = iv; in_pc = pc; in_data = d; out_ready = ordy;
        if (r) begin
            mq.delete();
            mLastPc = RPC;
            mStall  = 0;
        end else begin
            accept = iv && (mq.size() < 2) && !f;
            popped = (mq.size() > 0) && ordy;
            if (mq.size() > 0 && !ordy) mStall++;
            if (f) begin
                mq.delete();
            end else begin
                if (popped) void'(mq.pop_front());
                if (accept) begin
                    e.pc = pc; e.data = d;
                    mq.push_back(e);
                end
                if (mq.size() > 0) mLastPc = mq[0].pc;
            end
        end
        @(posedge clk); #1;
        checkModel();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_data = '0; out_ready = 1'b0;
        mLastPc = RPC; mStall = 0;

        //         rst fl iv pc           ordy  vld pc           occ rdy
        vecs.push_back(mk(1, 0, 0, 64'h0,   0,  0, RPC,         0, 1));
        vecs.push_back(mk(0, 0, 0, 64'h0,   0,  0, RPC,         0, 1));
        vecs.push_back(mk(0, 0, 0, 64'h0,   1,  0, RPC,         0, 1));
        vecs.push_back(mk(0, 0, 0, 64'h0,   1,  0, RPC,         0, 1));
        vecs.push_back(mk(0, 0, 1, 64'h100, 1,  1, 64'h100,     1, 1));
        vecs.push_back(mk(0, 0, 1, 64'h104, 1,  1, 64'h104,     1, 1));
        vecs.push_back(mk(0, 0, 1, 64'h108, 1,  1, 64'h108,     1, 1));
        vecs.push_back(mk(0, 0, 0, 64'h0,   1,  0, 64'h108,     0, 1));
        vecs.push_back(mk(0, 0, 1, 64'h200, 0,  1, 64'h200,     1, 1));
        vecs.push_back(mk(0, 0, 1, 64'h204, 0,  1, 64'h200,     2, 0));
        vecs.push_back(mk(0, 0, 1, 64'h208, 0,  1, 64'h200,     2, 0));
        vecs.push_back(mk(0, 0, 1, 64'h208, 1,  1, 64'h204,     1, 1));
        vecs.push_back(mk(0, 0, 1, 64'h208, 1,  1, 64'h208,     1, 1));
        vecs.push_back(mk(0, 0, 0, 64'h0,   1,  0, 64'h208,     0, 1));
        vecs.push_back(mk(0, 0, 1, 64'h2A0, 0,  1, 64'h2A0,     1, 1));
        vecs.push_back(mk(0, 0, 1, 64'h2A4, 0,  1, 64'h2A0,     2, 0));
        vecs.push_back(mk(0, 1, 1, 64'h300, 0,  0, 64'h2A0,     0, 1));
        vecs.push_back(mk(0, 0, 0, 64'h0,   1,  0, 64'h2A0,     0, 1));
        vecs.push_back(mk(0, 0, 1, 64'h400, 0,  1, 64'h400,     1, 1));
        vecs.push_back(mk(0, 0, 1, 64'h404, 0,  1, 64'h400,     2, 0));
        vecs.push_back(mk(1, 0, 1, 64'h500, 1,  0, RPC,         0, 1));
        vecs.push_back(mk(0, 0, 0, 64'h0,   1,  0, RPC,         0, 1));
        vecs.push_back(mk(0, 0, 1, 64'h600, 0,  1, 64'h600,     1, 1));
        vecs.push_back(mk(0, 1, 0, 64'h0,   1,  0, 64'h600,     0, 1));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].pc, dataOf(vecs[i].pc), vecs[i].ordy);
            chk($sformatf("vec%0d_vld", i), {63'b0, out_valid}, {63'b0, vecs[i].expVld});
            chk($sformatf("vec%0d_pc", i),  out_pc, vecs[i].expPc);
            chk($sformatf("vec%0d_occ", i), {62'b0, occupancy}, {62'b0, vecs[i].expOcc});
            chk($sformatf("vec%0d_rdy", i), {63'b0, in_ready}, {63'b0, vecs[i].expRdy});
            chk($sformatf("vec%0d_data", i), {32'b0, out_data},
                vecs[i].expVld ? {32'b0, dataOf(vecs[i].expPc)} : 64'h0);
        end

        // Stall counting and saturation of the 4-bit counter.
        step(1, 0, 0, 64'h0, 32'h0, 0);
        chk("stall_after_reset", {32'b0, stall_cnt}, 64'h0);
        step(0, 0, 1, 64'h700, dataOf(64'h700), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 64'h0, 32'h0, 0);
        chk("stall_5",     {32'b0, stall_cnt},   64'd5);
        chk("sat_stall_5", {60'b0, s_stall_cnt}, 64'd5);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 64'h0, 32'h0, 0);
        chk("stall_20",     {32'b0, stall_cnt},   64'd20);
        chk("sat_stall_20", {60'b0, s_stall_cnt}, 64'd15);
        chk("stall_hold_pc", out_pc, 64'h700);
        step(0, 1, 0, 64'h0, 32'h0, 0);
        chk("stall_flush_cycle", {32'b0, stall_cnt}, 64'd21);
        step(0, 0, 0, 64'h0, 32'h0, 0);
        chk("stall_no_valid", {32'b0, stall_cnt}, 64'd21);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic r, f, iv, ordy;
            r    = ($urandom_range(0, 199) == 0);
            f    = ($urandom_range(0, 39) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            step(r, f, iv, {32'h0, $urandom}, $urandom, ordy);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline stage register for the EX->MEM boundary and any later stage boundary in the core.
- Replaces the fixed-struct, wait-held stage register with a generic WIDTH-bit payload plus 64-bit PC, driven by a valid/ready handshake.
- A one-entry skid buffer lets the upstream ready be a registered signal, so back-pressure from the D-cache wait does not form a long combinational path.
- Adds an explicit flush and a saturating stall-cycle performance counter.

Parameters:
- WIDTH, 128, payload width in bits (packed stage struct excluding PC).
- RESET_PC, 64'h8000_0000, PC value presented on out_pc after reset.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries and any same-cycle input.
- in_valid  in  1  upstream presents an entry.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- in_pc  in  64  upstream PC.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts (low while the D-cache waits).
- out_pc  out  64  main entry PC.
- out_data  out  WIDTH  main entry payload; forced to 0 when !out_valid (bubble, ctl=0).
- out_bubble  out  1  equals !out_valid.
- occupancy  out  2  number of held entries: 0, 1 or 2.
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready; saturates at all-ones.

Behaviour:
- Handshake events: push = in_valid && in_ready && !flush; pop = out_valid && out_ready.
- Storage: main entry {pc, data, valid} and skid entry {pc, data, valid}.
- State is encoded by occupancy: EMPTY (0), ONE (1), TWO (2).
- Reset has highest priority. On reset: both valid bits clear, out_pc = RESET_PC, out_data = 0, out_bubble = 1, occupancy = 0, in_ready = 1, stall_cnt = 0.
- Flush is second priority. On flush: both valid bits clear, state goes to EMPTY, and the same-cycle input is dropped. The main PC register is not modified. in_ready = 1 next cycle. stall_cnt still updates for the flush cycle.
- EMPTY:
  - push: main <= input, go to ONE.
  - otherwise stay in EMPTY.
  - A pop cannot happen in EMPTY.
- ONE:
  - push && pop: main <= input, stay in ONE (full throughput).
  - push only: skid <= input, go to TWO.
  - pop only: main.valid <= 0, go to EMPTY.
  - neither: hold.
- TWO:
  - in_ready = 0, so push cannot occur; in_valid is ignored.
  - pop: main <= skid, skid.valid <= 0, go to ONE.
  - no pop: hold both entries unchanged.
- Ordering: entries leave in arrival order. The skid entry is never visible on the outputs before the main entry.
- Latency: one cycle from push to out_valid when the stage is empty. No combinational path from in_* to out_*, nor from out_ready to in_ready.
- Output stability: out_pc and out_data stay stable while out_valid && !out_ready.
- out_pc when invalid: shows the last main PC (or RESET_PC after reset); out_data reads 0.
- stall_cnt:
  - increments by 1 each cycle out_valid && !out_ready holds.
  - holds once at 2^CNT_W-1.
  - never wraps.
  - cleared only by reset.
- Simultaneous flush && pop: the pop is honoured downstream that cycle (downstream consumes the current entry); the state is still EMPTY afterwards.
- Reset during TWO: both entries are lost, no pop is produced, and state returns to EMPTY.

Test Plan:
- Reset then idle 3 cycles -> out_pc = 0x8000_0000, out_valid = 0, out_data = 0, in_ready = 1, occupancy = 0, stall_cnt = 0.
- Stream pc 0x100, 0x104, 0x108 with out_ready = 1 -> each appears one cycle after push, one per cycle, occupancy stays 1, in_ready never drops.
- out_ready = 0, push 0x200 then 0x204 -> occupancy = 2, in_ready = 0 on the following cycle, out_pc holds 0x200; 0x208 offered while full is not accepted. Then out_ready = 1 -> pops in order 0x200, 0x204, 0x208.
- Occupancy 2, assert flush with in_valid = 1 (pc 0x300) -> next cycle occupancy = 0, out_valid = 0, out_data = 0, in_ready = 1; 0x300 never appears.
- out_valid = 1, out_ready = 0 for 5 cycles -> stall_cnt = 5. With CNT_W = 4 and 20 stall cycles -> stall_cnt = 15 (saturated).
- Occupancy 2, assert reset for 1 cycle -> all reset values restored; the held entries are never popped.
